// File: rtl/encoder_hidden_state_collector.sv
// Packs NB upstream W-bit slices per time step into rows, buffers T rows, then streams them out.
// Optional sticky dropped-slice flag on port err when COLLECT_ERR_FLAG_EN is defined.
//   state  | meaning
//   FILL   | assembling slices into rows, writing rows to the buffer
//   DRAIN  | presenting buf[rd_ptr] on out_data with out_valid=1
//   DONE   | all rows delivered; idle until start or reset
module encoder_hidden_state_collector #(
    parameter int W  = 16,
    parameter int NB = 4,
    parameter int T  = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    in_data,
    input  logic            in_valid,
    output logic [NB*W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_idx,
    output logic            out_last,
    output logic            fill_done,
    output logic            done
`ifdef COLLECT_ERR_FLAG_EN
    ,
    output logic            err
`endif
);

    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [BW-1:0] BLK_LAST = BW'(NB - 1);
    localparam logic [4:0] ROW_LAST = 5'(T - 1);

    logic [1:0]      state_q, state_d;
    logic [BW-1:0]   blk_cnt_q, blk_cnt_d;
    logic [4:0]      row_cnt_q, row_cnt_d;
    logic [4:0]      rd_ptr_q, rd_ptr_d;
    logic [NB*W-1:0] asm_q, asm_d;
    logic            fill_done_q, fill_done_d;
    logic            done_q, done_d;
    logic            row_we;
    logic [NB*W-1:0] row_wdata;
    logic [NB*W-1:0] buf_mem [T];

    always_comb begin
        state_d     = state_q;
        blk_cnt_d   = blk_cnt_q;
        row_cnt_d   = row_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        asm_d       = asm_q;
        fill_done_d = fill_done_q;
        done_d      = done_q;
        row_we      = 1'b0;
        // The completing slice goes straight into the buffer word, not via asm_q.
        row_wdata   = asm_q;
        row_wdata[blk_cnt_q*W +: W] = in_data;

        if (start) begin
            state_d     = S_FILL;
            blk_cnt_d   = '0;
            row_cnt_d   = '0;
            rd_ptr_d    = '0;
            asm_d       = '0;
            fill_done_d = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_valid) begin
                        asm_d = row_wdata;
                        if (blk_cnt_q == BLK_LAST) begin
                            row_we    = 1'b1;
                            blk_cnt_d = '0;
                            row_cnt_d = row_cnt_q + 5'd1;
                            if (row_cnt_q == ROW_LAST) begin
                                state_d     = S_DRAIN;
                                fill_done_d = 1'b1;
                                rd_ptr_d    = '0;
                            end
                        end else begin
                            blk_cnt_d = blk_cnt_q + BW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr_q == ROW_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            blk_cnt_q   <= '0;
            row_cnt_q   <= '0;
            rd_ptr_q    <= '0;
            asm_q       <= '0;
            fill_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_cnt_q   <= blk_cnt_d;
            row_cnt_q   <= row_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            asm_q       <= asm_d;
            fill_done_q <= fill_done_d;
            done_q      <= done_d;
        end
    end

    // Row storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (row_we) begin
            buf_mem[row_cnt_q] <= row_wdata;
        end
    end

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? buf_mem[rd_ptr_q] : '0;
    assign out_idx   = rd_ptr_q;
    assign out_last  = out_valid && (rd_ptr_q == ROW_LAST);
    assign fill_done = fill_done_q;
    assign done      = done_q;

`ifdef COLLECT_ERR_FLAG_EN
    logic err_q, err_d;

    always_comb begin
        if (start) begin
            err_d = in_valid;
        end else begin
            err_d = err_q | (in_valid && (state_q != S_FILL));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_encoder_hidden_state_collector.sv
// Directed bench for encoder_hidden_state_collector: fill, drain, backpressure, drops, restart.
module tb_encoder_hidden_state_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        fill_done;
    logic        done;
`ifdef COLLECT_ERR_FLAG_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    encoder_hidden_state_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .fill_done (fill_done),
        .done      (done)
`ifdef COLLECT_ERR_FLAG_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_row(input int t);
        logic [7:0] tb8;
        tb8 = 8'(t);
        return {tb8, 8'h03, tb8, 8'h02, tb8, 8'h01, tb8, 8'h00};
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fill_done !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_clear: valid=%b fill_done=%b done=%b, need 0 0 0",
                     out_valid, fill_done, done);
        end
`ifdef COLLECT_ERR_FLAG_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL start_err_clear: err=%b need 0", err);
        end
`endif
    endtask

    // Sends the 120 standard slices; leaves the bench at the negedge after the last one.
    task automatic send_normal(input bit gaps);
        for (int t = 0; t < 30; t++) begin
            for (int b = 0; b < 4; b++) begin
                if (gaps) begin
                    int g;
                    g = int'($urandom_range(0, 3));
                    for (int k = 0; k < g; k++) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk);
                if (t == 29 && b == 3) begin
                    checks++;
                    if (fill_done !== 1'b0 || out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL early_fill: fill_done=%b valid=%b before last slice, need 0 0",
                                 fill_done, out_valid);
                    end
                end
                in_valid = 1'b1;
                in_data  = 16'((t << 8) | b);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        checks++;
        if (fill_done !== 1'b1 || out_valid !== 1'b1 || out_idx !== 5'd0) begin
            errors++;
            $display("FAIL fill_complete: fill_done=%b valid=%b idx=%0d, need 1 1 0",
                     fill_done, out_valid, out_idx);
        end
    endtask

    task automatic drain(input bit toggle, input string tag);
        int hs = 0;
        int cyc = 0;
        bit rdy;
        while (hs < 30 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 5'(hs) || out_data !== exp_row(hs)
                || out_last !== (hs == 29)) begin
                errors++;
                $display("FAIL %s_row%0d: valid=%b idx=%0d data=%h last=%b, need 1 %0d %h %b",
                         tag, hs, out_valid, out_idx, out_data, out_last, hs, exp_row(hs), hs == 29);
            end
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            out_ready = rdy;
            if (rdy) hs++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (hs != 30 || done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: handshakes=%0d done=%b valid=%b last=%b, need 30 1 0 0",
                     tag, hs, done, out_valid, out_last);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_idx !== 5'd0 || out_last !== 1'b0
            || fill_done !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h idx=%0d last=%b fill_done=%b done=%b, need all 0",
                     out_valid, out_data, out_idx, out_last, fill_done, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_start();
        send_normal(1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_idx !== 5'd0 || out_last !== 1'b0
            || fill_done !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b data=%h idx=%0d last=%b fill_done=%b done=%b, need all 0",
                     out_valid, out_data, out_idx, out_last, fill_done, done);
        end
`ifdef COLLECT_ERR_FLAG_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_err: err=%b need 0", err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send_normal(1'b0);
        drain(1'b0, "postreset");
    endtask

    task automatic test_fill_drain();
        do_start();
        send_normal(1'b0);
        drain(1'b0, "basic");
    endtask

    task automatic test_backpressure();
        do_start();
        send_normal(1'b0);
        drain(1'b1, "bp");
    endtask

    task automatic test_drop();
        do_start();
        send_normal(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'hFFFF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== exp_row(0)) begin
            errors++;
            $display("FAIL drop_drain: valid=%b idx=%0d data=%h, need 1 0 %h",
                     out_valid, out_idx, out_data, exp_row(0));
        end
`ifdef COLLECT_ERR_FLAG_EN
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL drop_err: err=%b need 1", err);
        end
`endif
        drain(1'b0, "drop");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || fill_done !== 1'b1) begin
            errors++;
            $display("FAIL drop_done: done=%b valid=%b fill_done=%b, need 1 0 1",
                     done, out_valid, fill_done);
        end
    endtask

    task automatic test_restart();
        do_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'hA000 | 16'(i);
        end
        // start coincides with a slice that must be ignored
        @(negedge clk);
        in_data = 16'hBEEF;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (fill_done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: fill_done=%b valid=%b, need 0 0", fill_done, out_valid);
        end
`ifdef COLLECT_ERR_FLAG_EN
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL restart_err: err=%b need 1", err);
        end
`endif
        send_normal(1'b0);
        checks++;
        if (out_data[15:0] !== 16'h0000 || out_data[31:16] !== 16'h0001) begin
            errors++;
            $display("FAIL restart_row0: blk0=%h blk1=%h, need 0000 0001",
                     out_data[15:0], out_data[31:16]);
        end
        drain(1'b0, "restart");
    endtask

    task automatic test_gaps();
        do_start();
        send_normal(1'b1);
        drain(1'b0, "gaps");
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fill_drain();
        test_backpressure();
        test_drop();
        test_restart();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
